// File: rtl/regex_cpu_memory_arbiter_pkg.sv
// rtl/regex_cpu_memory_arbiter_pkg.sv - shared constants for the regex_cpu instruction-memory arbiter
package regex_cpu_memory_arbiter_pkg;

   localparam int unsigned DEFAULT_N_CPU             = 4;
   localparam int unsigned DEFAULT_MEMORY_WIDTH      = 16;
   localparam int unsigned DEFAULT_MEMORY_ADDR_WIDTH = 11;
   localparam int unsigned CPU_ID_WIDTH              = $clog2(DEFAULT_N_CPU);

   // Index width for an N-entry pool; never below 1 so a bus always exists.
   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regex_cpu_memory_arbiter_rr_priority_picker.sv
// rtl/regex_cpu_memory_arbiter_rr_priority_picker.sv - combinational round-robin first-requester picker
module rr_priority_picker
   import regex_cpu_memory_arbiter_pkg::*;
#(
   parameter int N = 4,
   localparam int W = id_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] winner,
   output logic         any
);

   // idx[k] is the k-th candidate in scan order starting at ptr.
   logic [W-1:0] idx [N];

   for (genvar g = 0; g < N; g++) begin : g_scan
      assign idx[g] = W'((32'(ptr) + g) % N);
   end

   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[idx[k]]) begin
            any             = 1'b1;
            winner          = idx[k];
            grant[idx[k]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regex_cpu_memory_arbiter.sv
// rtl/regex_cpu_memory_arbiter.sv - shares one instruction BRAM among N_CPU regex_cpu fetch ports
module regex_cpu_memory_arbiter
   import regex_cpu_memory_arbiter_pkg::*;
#(
   parameter int N_CPU             = DEFAULT_N_CPU,
   parameter int MEMORY_WIDTH      = DEFAULT_MEMORY_WIDTH,
   parameter int MEMORY_ADDR_WIDTH = DEFAULT_MEMORY_ADDR_WIDTH,
   parameter int COALESCE          = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_CPU-1:0]                     cpu_memory_valid,
   input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_memory_addr,
   output logic [N_CPU-1:0]                     cpu_memory_ready,
   output logic [MEMORY_WIDTH-1:0]              cpu_memory_data,
   output logic                                 bram_en,
   output logic [MEMORY_ADDR_WIDTH-1:0]         bram_addr,
   input  logic [MEMORY_WIDTH-1:0]              bram_data
);

   localparam int IW = id_width(N_CPU);
   localparam int AW = MEMORY_ADDR_WIDTH;

   logic [IW-1:0]    ptr;
   logic [IW-1:0]    winner;
   logic [IW-1:0]    ptr_next;
   logic [N_CPU-1:0] pick;
   logic             any;
   logic             grant_ok;
   logic [AW-1:0]    win_addr;
   logic [AW-1:0]    addr_q;
   logic [AW-1:0]    addr [N_CPU];

   for (genvar g = 0; g < N_CPU; g++) begin : g_addr
      assign addr[g] = cpu_memory_addr[g*AW +: AW];
   end

   rr_priority_picker #(.N(N_CPU)) u_picker (
      .req    (cpu_memory_valid),
      .ptr    (ptr),
      .grant  (pick),
      .winner (winner),
      .any    (any)
   );

   // Reset suppresses the grant outright, so no core ever consumes that cycle's read.
   assign grant_ok = any & ~rst;
   assign win_addr = addr[winner];
   assign ptr_next = (winner == IW'(N_CPU - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      cpu_memory_ready = '0;
      if (grant_ok) begin
         for (int i = 0; i < N_CPU; i++) begin
            if (COALESCE != 0)
               cpu_memory_ready[i] = cpu_memory_valid[i] && (addr[i] == win_addr);
            else
               cpu_memory_ready[i] = pick[i];
         end
      end
   end

   assign bram_en         = grant_ok;
   assign bram_addr       = grant_ok ? win_addr : addr_q;
   assign cpu_memory_data = bram_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         addr_q <= '0;
      end else if (grant_ok) begin
         ptr    <= ptr_next;
         addr_q <= win_addr;
      end
   end

endmodule

// File: tb/tb_regex_cpu_memory_arbiter.sv
// tb/tb_regex_cpu_memory_arbiter.sv - scoreboard bench for regex_cpu_memory_arbiter
module tb_regex_cpu_memory_arbiter;

   localparam int N  = 4;
   localparam int AW = 11;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    valid;
   logic [N*AW-1:0] addr_bus;
   logic [N-1:0]    cpu_memory_ready;
   logic [DW-1:0]   cpu_memory_data;
   logic            bram_en;
   logic [AW-1:0]   bram_addr;
   logic [DW-1:0]   bram_data;

   regex_cpu_memory_arbiter #(
      .N_CPU(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .COALESCE(1)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_memory_valid (valid),
      .cpu_memory_addr  (addr_bus),
      .cpu_memory_ready (cpu_memory_ready),
      .cpu_memory_data  (cpu_memory_data),
      .bram_en          (bram_en),
      .bram_addr        (bram_addr),
      .bram_data        (bram_data)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [2048];
   always @(posedge clk) if (bram_en) bram_data <= mem[bram_addr];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Core-side state: each core holds its request until it sees ready.
   logic [AW-1:0] core_addr [N];
   logic [AW-1:0] req_list  [N][$];
   int            wait_cnt  [N];
   bit            rand_en;
   logic [N-1:0]  dut_ready;

   // Reference model state and per-core expected-data scoreboard.
   int            m_ptr;
   logic [AW-1:0] m_last;
   logic [DW-1:0] exp_q [N][$];

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return AW'(11'h020 + $urandom_range(0, 1));
      return AW'($urandom_range(0, 2047));
   endfunction

   task automatic update_cores();
      for (int j = 0; j < N; j++) begin
         if (valid[j] && dut_ready[j]) begin
            valid[j] = 1'b0;
         end else if (!valid[j]) begin
            if (req_list[j].size() > 0) begin
               core_addr[j] = req_list[j].pop_front();
               valid[j]     = 1'b1;
               wait_cnt[j]  = 0;
            end else if (rand_en && $urandom_range(0, 2) != 0) begin
               core_addr[j] = rand_addr();
               valid[j]     = 1'b1;
               wait_cnt[j]  = 0;
            end
         end
      end
      for (int j = 0; j < N; j++) addr_bus[j*AW +: AW] = core_addr[j];
      dut_ready = '0;
   endtask

   task automatic check_phase();
      int            win;
      logic [AW-1:0] wa;
      logic [N-1:0]  exp_ready;
      @(negedge clk);
      win       = -1;
      wa        = '0;
      exp_ready = '0;
      if (!rst) begin
         for (int k = 0; k < N; k++)
            if (win < 0 && valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
         wa = core_addr[win];
         for (int j = 0; j < N; j++)
            if (valid[j] && core_addr[j] == wa) exp_ready[j] = 1'b1;
      end
      check("ready", 32'(cpu_memory_ready), 32'(exp_ready));
      check("bram_en", 32'(bram_en), 32'(win >= 0));
      check("bram_addr", 32'(bram_addr), 32'((win >= 0) ? wa : m_last));
      for (int j = 0; j < N; j++) begin
         if (exp_ready[j]) exp_q[j].push_back(mem[wa]);
         if (rst) wait_cnt[j] = 0;
         else if (valid[j]) begin
            if (cpu_memory_ready[j]) check("fair_wait", 32'(wait_cnt[j] < N), 32'd1);
            else wait_cnt[j]++;
         end
      end
      dut_ready = cpu_memory_ready;
      if (rst) begin
         m_ptr  = 0;
         m_last = '0;
      end else if (win >= 0) begin
         m_ptr  = (win + 1) % N;
         m_last = wa;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      update_cores();
   endtask

   task automatic cycle();
      check_phase();
      advance();
   endtask

   task automatic drain();
      rand_en = 1'b0;
      for (int j = 0; j < N; j++) req_list[j].delete();
      repeat (12) cycle();
   endtask

   // Monitor: a core granted at the previous edge consumes cpu_memory_data now.
   logic [N-1:0] prev_ready = '0;
   always @(posedge clk) prev_ready <= cpu_memory_ready;

   always @(negedge clk) begin
      for (int j = 0; j < N; j++) begin
         if (prev_ready[j]) begin
            if (exp_q[j].size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("data", 32'(cpu_memory_data), 32'(exp_q[j].pop_front()));
         end
      end
   end

   initial begin
      int  t3_cyc;
      bit  t3_done;
      for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
      mem[5]    = 16'h1234;
      bram_data = '0;
      rst       = 1'b1;
      valid     = '0;
      addr_bus  = '0;
      rand_en   = 1'b0;
      dut_ready = '0;
      m_ptr     = 0;
      m_last    = '0;
      for (int j = 0; j < N; j++) begin core_addr[j] = '0; wait_cnt[j] = 0; end
      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;

      // Single requester, same-cycle grant, data one cycle later.
      req_list[2].push_back(11'h005);
      update_cores();
      check_phase();
      check("t1_ready", 32'(cpu_memory_ready), 32'b0100);
      check("t1_bram_en", 32'(bram_en), 32'd1);
      check("t1_bram_addr", 32'(bram_addr), 32'h005);
      advance();
      check_phase();
      check("t1_data", 32'(cpu_memory_data), 32'h1234);
      advance();
      drain();

      // All four requesting from reset: strict rotation.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int j = 0; j < N; j++) repeat (3) req_list[j].push_back(AW'(11'h010 + j));
      update_cores();
      for (int k = 0; k < 8; k++) begin
         check_phase();
         check($sformatf("t2_rot%0d", k), 32'(cpu_memory_ready), 32'(1 << (k % 4)));
         advance();
      end
      drain();

      // cpu0 hammering, cpu3 must still be served within N cycles.
      repeat (8) req_list[0].push_back(11'h050);
      update_cores();
      cycle();
      cycle();
      req_list[3].push_back(11'h053);
      t3_cyc  = 0;
      t3_done = 1'b0;
      repeat (10) begin
         check_phase();
         if (valid[3] && !t3_done) begin
            t3_cyc++;
            if (cpu_memory_ready[3]) begin
               t3_done = 1'b1;
               check("t3_within_n", 32'(t3_cyc <= N), 32'd1);
            end
         end
         advance();
      end
      check("t3_granted", 32'(t3_done), 32'd1);
      drain();

      // Coalescing from ptr=0.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req_list[1].push_back(11'h020);
      req_list[3].push_back(11'h020);
      req_list[2].push_back(11'h030);
      update_cores();
      check_phase();
      check("t4_ready0", 32'(cpu_memory_ready), 32'b1010);
      check("t4_addr0", 32'(bram_addr), 32'h020);
      advance();
      check_phase();
      check("t4_ready1", 32'(cpu_memory_ready), 32'b0100);
      check("t4_addr1", 32'(bram_addr), 32'h030);
      advance();
      drain();

      // Reset pulse with three cores waiting.
      req_list[1].push_back(11'h041);
      req_list[2].push_back(11'h042);
      req_list[3].push_back(11'h043);
      update_cores();
      rst = 1'b1;
      check_phase();
      check("t5_rst_ready", 32'(cpu_memory_ready), 32'd0);
      check("t5_rst_en", 32'(bram_en), 32'd0);
      advance();
      rst = 1'b0;
      check_phase();
      check("t5_first", 32'(cpu_memory_ready), 32'b0010);
      advance();
      drain();

      // Randomized traffic with occasional resets.
      rand_en = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;
      drain();
      for (int j = 0; j < N; j++) check($sformatf("sb_empty%0d", j), 32'(exp_q[j].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
